// File: rtl/reduce_pkg.sv
// reduce_pkg: shared types and the bitwise combine used by the reduction unit.
//   mode_t  - frame reduction mode (AND / OR / XOR / reserved)
//   state_t - frame FSM states
//   red_op  - bitwise combine of two operands under a mode. Operands are
//             OP_W bits wide; narrower callers zero-extend and truncate.
package reduce_pkg;

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  // Widest lane supported; red_op works at this width for every caller.
  localparam int OP_W = 32;

  // The reserved mode folds as AND so a bad frame still yields a defined word.
  function automatic logic [OP_W-1:0] red_op(input mode_t mode,
                                             input logic [OP_W-1:0] a,
                                             input logic [OP_W-1:0] b);
    case (mode)
      MODE_OR:  red_op = a | b;
      MODE_XOR: red_op = a ^ b;
      default:  red_op = a & b;
    endcase
  endfunction

endpackage

// File: rtl/reduce_accum_if.sv
// reduce_accum_if: beat input and result output handshakes of reduce_accum.
//   in_valid/in_ready/in_data/in_mode/in_last - beat stream into the unit
//   out_valid/out_ready/out_data/out_flag/out_beats/out_err - frame results
// modport slave is the reduction unit, modport master is its environment.
interface reduce_accum_if #(
  parameter int PORT_NUM = 8,
  parameter int WIDTH    = 7,
  parameter int CNT_W    = 8
);

  logic                      in_valid;
  logic                      in_ready;
  logic [PORT_NUM*WIDTH-1:0] in_data;
  logic [1:0]                in_mode;
  logic                      in_last;

  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      out_flag;
  logic [CNT_W-1:0]          out_beats;
  logic                      out_err;

  modport master (
    output in_valid, in_data, in_mode, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_flag, out_beats, out_err
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_data, out_flag, out_beats, out_err
  );

endinterface

// File: rtl/reduce_lanes.sv
// reduce_lanes: combinational fold of PORT_NUM lanes of WIDTH bits into one
// WIDTH-bit word under the given mode.
//   mode  in  reduction mode (reserved folds as AND)
//   lanes in  lane k at bits [k*WIDTH +: WIDTH]
//   word  out bitwise reduction across all lanes
module reduce_lanes
  import reduce_pkg::*;
#(
  parameter int PORT_NUM = 8,
  parameter int WIDTH    = 7
) (
  input  mode_t                     mode,
  input  logic [PORT_NUM*WIDTH-1:0] lanes,
  output logic [WIDTH-1:0]          word
);

  // chain[k] holds the reduction of lanes 0..k.
  logic [WIDTH-1:0] chain [PORT_NUM];

  assign chain[0] = lanes[WIDTH-1:0];

  generate
    for (genvar gi = 1; gi < PORT_NUM; gi++) begin : g_fold
      assign chain[gi] = WIDTH'(red_op(mode, OP_W'(chain[gi-1]),
                                       OP_W'(lanes[gi*WIDTH +: WIDTH])));
    end
  endgenerate

  assign word = chain[PORT_NUM-1];

endmodule

// File: rtl/reduce_accum.sv
// reduce_accum: streaming reduction unit. Each accepted beat's lanes are
// folded into one word, words are folded across the frame, and the frame
// result is registered on the beat carrying in_last.
//   clk   in  rising-edge clock
//   reset in  synchronous active-high reset
//   bus   slave modport of reduce_accum_if (beat in, result out)
// The accumulator and the output register are independent, so the next
// frame streams in while a result waits; only a last beat stalls on a full
// output register.
module reduce_accum
  import reduce_pkg::*;
#(
  parameter int PORT_NUM = 8,
  parameter int WIDTH    = 7,
  parameter int CNT_W    = 8
) (
  input logic           clk,
  input logic           reset,
  reduce_accum_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg, state_next;
  mode_t            mode_reg, mode_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] beats_reg, beats_next;
  logic             err_reg, err_next;

  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic             out_flag_reg, out_flag_next;
  logic [CNT_W-1:0] out_beats_reg, out_beats_next;
  logic             out_err_reg, out_err_next;

  mode_t            in_mode_raw;
  mode_t            first_mode;
  mode_t            beat_mode;
  logic [WIDTH-1:0] beat_word;
  logic [WIDTH-1:0] merged_acc;
  logic [CNT_W-1:0] merged_beats;
  logic             merged_err;
  logic             merged_flag;
  logic             in_ready;
  logic             accept;

  // The frame mode comes from the beat that opens the frame; later beats
  // reuse the latched mode whatever in_mode says.
  always_comb begin
    in_mode_raw = mode_t'(bus.in_mode);
    first_mode  = (in_mode_raw == MODE_RSVD) ? MODE_AND : in_mode_raw;
    beat_mode   = (state_reg == S_IDLE) ? first_mode : mode_reg;
  end

  reduce_lanes #(
    .PORT_NUM (PORT_NUM),
    .WIDTH    (WIDTH)
  ) u_lanes (
    .mode  (beat_mode),
    .lanes (bus.in_data),
    .word  (beat_word)
  );

  // Only a last beat needs the output register, so only it can stall.
  assign in_ready     = !(out_valid_reg && !bus.out_ready && bus.in_last);
  assign accept       = bus.in_valid && in_ready;
  assign bus.in_ready = in_ready;

  // Frame state after folding in the offered beat.
  always_comb begin
    if (state_reg == S_IDLE) begin
      merged_acc   = beat_word;
      merged_beats = CNT_W'(1);
      merged_err   = (in_mode_raw == MODE_RSVD);
    end else begin
      merged_acc   = WIDTH'(red_op(mode_reg, OP_W'(acc_reg), OP_W'(beat_word)));
      merged_beats = (beats_reg == CNT_MAX) ? CNT_MAX : beats_reg + CNT_W'(1);
      merged_err   = err_reg || (beats_reg == CNT_MAX);
    end
    case (beat_mode)
      MODE_OR:  merged_flag = |merged_acc;
      MODE_XOR: merged_flag = ^merged_acc;
      default:  merged_flag = &merged_acc;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    mode_next      = mode_reg;
    acc_next       = acc_reg;
    beats_next     = beats_reg;
    err_next       = err_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_flag_next  = out_flag_reg;
    out_beats_next = out_beats_reg;
    out_err_next   = out_err_reg;

    if (out_valid_reg && bus.out_ready) begin
      out_valid_next = 1'b0;
    end

    if (accept) begin
      if (bus.in_last) begin
        // A load in the same cycle as a pop overrides the clear above.
        out_valid_next = 1'b1;
        out_data_next  = merged_acc;
        out_flag_next  = merged_flag;
        out_beats_next = merged_beats;
        out_err_next   = merged_err;
        state_next     = S_IDLE;
        mode_next      = MODE_AND;
        acc_next       = '0;
        beats_next     = '0;
        err_next       = 1'b0;
      end else begin
        state_next = S_ACCUM;
        mode_next  = beat_mode;
        acc_next   = merged_acc;
        beats_next = merged_beats;
        err_next   = merged_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      mode_reg      <= MODE_AND;
      acc_reg       <= '0;
      beats_reg     <= '0;
      err_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_flag_reg  <= 1'b0;
      out_beats_reg <= '0;
      out_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      acc_reg       <= acc_next;
      beats_reg     <= beats_next;
      err_reg       <= err_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_flag_reg  <= out_flag_next;
      out_beats_reg <= out_beats_next;
      out_err_reg   <= out_err_next;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_flag  = out_flag_reg;
  assign bus.out_beats = out_beats_reg;
  assign bus.out_err   = out_err_reg;

endmodule

// File: tb/tb_reduce_accum.sv
// tb_reduce_accum: drives two reduce_accum instances (CNT_W=8 and CNT_W=2)
// with the same beat stream and checks results against a frame-level model.
module tb_reduce_accum;

  localparam int PN = 8;
  localparam int W  = 7;
  localparam int DW = PN * W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid  = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic [1:0]    in_mode   = 2'b00;
  logic          in_last   = 1'b0;
  logic          out_ready = 1'b1;

  reduce_accum_if #(.PORT_NUM(PN), .WIDTH(W), .CNT_W(8)) a_if ();
  reduce_accum_if #(.PORT_NUM(PN), .WIDTH(W), .CNT_W(2)) b_if ();

  assign a_if.in_valid  = in_valid;
  assign a_if.in_data   = in_data;
  assign a_if.in_mode   = in_mode;
  assign a_if.in_last   = in_last;
  assign a_if.out_ready = out_ready;
  assign b_if.in_valid  = in_valid;
  assign b_if.in_data   = in_data;
  assign b_if.in_mode   = in_mode;
  assign b_if.in_last   = in_last;
  assign b_if.out_ready = out_ready;

  reduce_accum #(.PORT_NUM(PN), .WIDTH(W), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if.slave));
  reduce_accum #(.PORT_NUM(PN), .WIDTH(W), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if.slave));

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Beats of the frame most recently sent, for the model.
  logic [DW-1:0] frame_q[$];

  // Expected {data, flag, beats(8b), err} straight from the frame rules.
  function automatic logic [16:0] model(input logic [1:0] m, input int cw);
    logic [1:0]    op;
    logic [6:0]    acc;
    logic [DW-1:0] beat;
    logic [6:0]    lane;
    logic          flag;
    int            n, maxc, bts;
    op  = (m == 2'b11) ? 2'b00 : m;
    acc = (op == 2'b00) ? 7'h7F : 7'h00;
    foreach (frame_q[i]) begin
      beat = frame_q[i];
      for (int k = 0; k < PN; k++) begin
        lane = beat[k*W +: W];
        case (op)
          2'b00:   acc = acc & lane;
          2'b01:   acc = acc | lane;
          default: acc = acc ^ lane;
        endcase
      end
    end
    flag = (op == 2'b00) ? &acc : (op == 2'b01) ? |acc : ^acc;
    n    = frame_q.size();
    maxc = (1 << cw) - 1;
    bts  = (n > maxc) ? maxc : n;
    return {acc, flag, 8'(bts), (m == 2'b11) || (n > maxc)};
  endfunction

  function automatic logic [16:0] got_a();
    return {a_if.out_data, a_if.out_flag, a_if.out_beats, a_if.out_err};
  endfunction

  function automatic logic [16:0] got_b();
    return {b_if.out_data, b_if.out_flag, 6'b0, b_if.out_beats, b_if.out_err};
  endfunction

  function automatic logic [DW-1:0] all_lanes(input logic [6:0] v);
    logic [DW-1:0] d;
    for (int k = 0; k < PN; k++) d[k*W +: W] = v;
    return d;
  endfunction

  // AND-style frames mostly keep bits set so the result is not trivially 0.
  function automatic logic [DW-1:0] rand_beat(input logic [1:0] m);
    logic [DW-1:0] d;
    for (int k = 0; k < PN; k++) begin
      if (m == 2'b00 || m == 2'b11)
        d[k*W +: W] = 7'h7F ^ (($urandom_range(0, 3) == 0) ? 7'(1 << $urandom_range(0, 6)) : 7'h00);
      else
        d[k*W +: W] = 7'($urandom);
    end
    return d;
  endfunction

  // Offer a beat at a negedge, wait (bounded) for in_ready, and return at
  // the negedge after the accepting edge. in_valid is left high.
  task automatic drive_beat(input logic [DW-1:0] d, input logic [1:0] m, input logic l);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_last  = l;
    #1;
    while (!(a_if.in_ready && b_if.in_ready) && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 100) begin
      total++;
      $display("FAIL beat_accept_timeout: in_ready=%0b after %0d cycles, required 1", a_if.in_ready, waited);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [1:0] m, input int len, input bit gaps);
    logic [DW-1:0] d;
    frame_q.delete();
    for (int i = 0; i < len; i++) begin
      d = rand_beat(m);
      frame_q.push_back(d);
      drive_beat(d, (i == 0) ? m : 2'($urandom), (i == len - 1));
      if (gaps && i < len - 1 && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (a_if.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b expected 0", a_if.out_valid);
    else passed++;
    total++;
    if (got_a() !== 17'h0) $display("FAIL reset_out_fields: got %h expected 00000", got_a());
    else passed++;
    total++;
    if (a_if.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b expected 1", a_if.in_ready);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_one_beat_and();
    logic [DW-1:0] d;
    out_ready = 1'b1;
    d = all_lanes(7'h7F);
    drive_beat(d, 2'b00, 1'b1);
    in_valid = 1'b0;
    total++;
    if (a_if.out_valid !== 1'b1 || got_a() !== {7'h7F, 1'b1, 8'd1, 1'b0})
      $display("FAIL and_all_ones: valid=%0b got %h expected %h", a_if.out_valid, got_a(), {7'h7F, 1'b1, 8'd1, 1'b0});
    else passed++;
    d[3*W +: W] = 7'h7E;
    drive_beat(d, 2'b00, 1'b1);
    in_valid = 1'b0;
    total++;
    if (a_if.out_valid !== 1'b1 || got_a() !== {7'h7E, 1'b0, 8'd1, 1'b0})
      $display("FAIL and_lane3_7e: valid=%0b got %h expected %h", a_if.out_valid, got_a(), {7'h7E, 1'b0, 8'd1, 1'b0});
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_or_three();
    logic [DW-1:0] d;
    d = '0; d[0*W +: W] = 7'h01; drive_beat(d, 2'b01, 1'b0);
    d = '0; d[5*W +: W] = 7'h10; drive_beat(d, 2'b00, 1'b0);
    d = '0; d[7*W +: W] = 7'h40; drive_beat(d, 2'b00, 1'b1);
    in_valid = 1'b0;
    total++;
    if (a_if.out_valid !== 1'b1 || got_a() !== {7'h51, 1'b1, 8'd3, 1'b0})
      $display("FAIL or_three_beat: valid=%0b got %h expected %h", a_if.out_valid, got_a(), {7'h51, 1'b1, 8'd3, 1'b0});
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_xor_two();
    logic [DW-1:0] d;
    for (int k = 0; k < PN; k++) d[k*W +: W] = 7'(k + 1);
    drive_beat(d, 2'b10, 1'b0);
    drive_beat(all_lanes(7'h55), 2'b01, 1'b1);
    in_valid = 1'b0;
    total++;
    if (a_if.out_valid !== 1'b1 || got_a() !== {7'h08, 1'b1, 8'd2, 1'b0})
      $display("FAIL xor_two_beat: valid=%0b got %h expected %h", a_if.out_valid, got_a(), {7'h08, 1'b1, 8'd2, 1'b0});
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_rsvd();
    logic [DW-1:0] d;
    d = all_lanes(7'h7F);
    d[2*W +: W] = 7'h3F;
    drive_beat(d, 2'b11, 1'b1);
    in_valid = 1'b0;
    total++;
    if (a_if.out_valid !== 1'b1 || got_a() !== {7'h3F, 1'b0, 8'd1, 1'b1})
      $display("FAIL reserved_mode: valid=%0b got %h expected %h", a_if.out_valid, got_a(), {7'h3F, 1'b0, 8'd1, 1'b1});
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    send_frame(2'b10, 5, 1'b0);
    total++;
    if (b_if.out_valid !== 1'b1 || b_if.out_beats !== 2'd3 || b_if.out_err !== 1'b1)
      $display("FAIL sat_cnt2: valid=%0b beats=%0d err=%0b expected valid 1 beats 3 err 1", b_if.out_valid, b_if.out_beats, b_if.out_err);
    else passed++;
    total++;
    if (got_b() !== model(2'b10, 2)) $display("FAIL sat_cnt2_model: got %h expected %h", got_b(), model(2'b10, 2));
    else passed++;
    total++;
    if (got_a() !== model(2'b10, 8)) $display("FAIL sat_cnt8_model: got %h expected %h", got_a(), model(2'b10, 8));
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] da, db;
    logic [16:0]   exp_a, exp_b;
    out_ready = 1'b0;
    da = rand_beat(2'b01);
    db = rand_beat(2'b10);
    frame_q = {da}; exp_a = model(2'b01, 8);
    frame_q = {db}; exp_b = model(2'b10, 8);
    drive_beat(da, 2'b01, 1'b1);
    total++;
    if (a_if.out_valid !== 1'b1 || got_a() !== exp_a)
      $display("FAIL bp_first_result: valid=%0b got %h expected %h", a_if.out_valid, got_a(), exp_a);
    else passed++;
    in_data = db; in_mode = 2'b10; in_last = 1'b1;
    #1;
    total++;
    if (a_if.in_ready !== 1'b0) $display("FAIL bp_in_ready_low: got %0b expected 0", a_if.in_ready);
    else passed++;
    repeat (2) @(negedge clk);
    total++;
    if (a_if.out_valid !== 1'b1 || got_a() !== exp_a)
      $display("FAIL bp_first_stable: valid=%0b got %h expected %h", a_if.out_valid, got_a(), exp_a);
    else passed++;
    out_ready = 1'b1;
    #1;
    total++;
    if (a_if.in_ready !== 1'b1) $display("FAIL bp_in_ready_release: got %0b expected 1", a_if.in_ready);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (a_if.out_valid !== 1'b1 || got_a() !== exp_b)
      $display("FAIL bp_second_result: valid=%0b got %h expected %h", a_if.out_valid, got_a(), exp_b);
    else passed++;
    @(negedge clk);
    total++;
    if (a_if.out_valid !== 1'b0) $display("FAIL bp_no_duplicate: out_valid=%0b expected 0", a_if.out_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    logic [1:0]    m;
    int            start;
    out_ready = 1'b1;
    start = cyc;
    for (int i = 0; i < 6; i++) begin
      m = 2'($urandom_range(0, 2));
      d = rand_beat(m);
      frame_q = {d};
      drive_beat(d, m, 1'b1);
      total++;
      if (a_if.out_valid !== 1'b1 || got_a() !== model(m, 8))
        $display("FAIL b2b_frame%0d: valid=%0b got %h expected %h", i, a_if.out_valid, got_a(), model(m, 8));
      else passed++;
    end
    in_valid = 1'b0;
    total++;
    if (cyc - start !== 6) $display("FAIL b2b_throughput: took %0d cycles expected 6", cyc - start);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [1:0] m;
    int         len;
    out_ready = 1'b1;
    for (int f = 0; f < 24; f++) begin
      m   = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 5);
      send_frame(m, len, 1'b1);
      total++;
      if (a_if.out_valid !== 1'b1 || got_a() !== model(m, 8))
        $display("FAIL rand_frame%0d_cnt8: mode=%0d len=%0d valid=%0b got %h expected %h", f, m, len, a_if.out_valid, got_a(), model(m, 8));
      else passed++;
      total++;
      if (b_if.out_valid !== 1'b1 || got_b() !== model(m, 2))
        $display("FAIL rand_frame%0d_cnt2: mode=%0d len=%0d valid=%0b got %h expected %h", f, m, len, b_if.out_valid, got_b(), model(m, 2));
      else passed++;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    // Pending result plus a half-received frame, then reset.
    out_ready = 1'b0;
    drive_beat(rand_beat(2'b01), 2'b01, 1'b1);
    drive_beat(all_lanes(7'h2A), 2'b01, 1'b0);
    drive_beat(all_lanes(7'h15), 2'b01, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (a_if.out_valid !== 1'b0 || got_a() !== 17'h0)
      $display("FAIL reset_mid_clear: valid=%0b got %h expected 0 / 00000", a_if.out_valid, got_a());
    else passed++;
    reset = 1'b0;
    out_ready = 1'b1;
    drive_beat(all_lanes(7'h00), 2'b01, 1'b1);
    in_valid = 1'b0;
    total++;
    if (a_if.out_valid !== 1'b1 || got_a() !== {7'h00, 1'b0, 8'd1, 1'b0})
      $display("FAIL reset_mid_fresh: valid=%0b got %h expected %h", a_if.out_valid, got_a(), {7'h00, 1'b0, 8'd1, 1'b0});
    else passed++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_one_beat_and();
    test_or_three();
    test_xor_two();
    test_rsvd();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reduce_accum.md
# reduce_accum

Parametrised streaming reduction unit that combines PORT_NUM lanes of WIDTH bits per beat and accumulates the result across a multi-beat frame.
- Reduction mode is AND, OR or XOR, selected per frame.
- Each completed frame produces one registered result word plus a 1-bit whole-word reduction flag.
- Valid/ready handshakes on both sides.
- Sits between the operand-gathering logic and the result-checking logic, replacing the fixed eight-input single-cycle reducer.

## Interface
Parameters:
- PORT_NUM, 8, number of input lanes (1..16)
- WIDTH, 7, bits per lane (1..32)
- CNT_W, 8, width of the beat counter

Ports:
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  beat offered
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_data  in  PORT_NUM*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH]
- in_mode  in  2  00 AND, 01 OR, 10 XOR, 11 reserved; sampled on the first beat of a frame only
- in_last  in  1  marks the final beat of a frame
- out_valid  out  1  result held
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  WIDTH  bitwise reduction over all lanes of all beats in the frame
- out_flag  out  1  reduction of out_data under the frame mode (&, |, ^)
- out_beats  out  CNT_W  accepted beats in the frame, saturating at 2^CNT_W-1
- out_err  out  1  frame mode was 11, or out_beats saturated

## Operation
- State machine with two states:
  - IDLE: no frame open.
  - ACCUM: frame open.
- Reset:
  - State goes to IDLE; accumulator is cleared.
  - out_valid, out_data, out_flag, out_beats and out_err all reset to 0.
- Beat combine: the PORT_NUM lanes of a beat are combined bitwise under the mode, giving a WIDTH-bit word.
- Accepted beat in IDLE:
  - Latch mode, with 11 mapped to AND and err set.
  - acc = combined word; beats = 1.
  - If in_last is low, go to ACCUM; otherwise emit immediately.
- Accepted beat in ACCUM:
  - acc = acc op combined word; beats = min(beats+1, max).
  - in_mode is ignored.
- Saturation: when beats is already at max and another beat is accepted, err is set; accumulation continues.
- Emit (accepted beat with in_last high):
  - Load the output registers and set out_valid.
  - Return to IDLE and clear the accumulator and err.
- A one-beat frame is legal. A frame has no upper length limit.
- Output register and accumulator are independent: beats of the next frame are accepted while a result is pending.

## Timing
- in_ready is low only when out_valid && !out_ready && the offered beat has in_last high.
- in_ready must not combinationally depend on out_ready beyond that term.
- Latency: a last beat accepted at edge t gives out_valid high after edge t, visible in cycle t+1.
- A one-beat frame has latency 1.
- Throughput: one beat per cycle. With out_ready held high, back-to-back one-beat frames give one result per cycle.
- Simultaneous output pop and new last beat in the same cycle: the new result is loaded and out_valid stays 1 with no bubble.
- out_* fields are stable while out_valid && !out_ready.
- in_valid low in ACCUM: hold state and accumulator indefinitely.
- Reset asserted mid-frame or with a pending result: both are discarded and the reset values above are reached the next cycle.
- in_ready is 1 in the first cycle after reset.

## Structure
- Package reduce_pkg holds:
  - typedef mode_t (MODE_AND=2'b00, MODE_OR=2'b01, MODE_XOR=2'b10, MODE_RSVD=2'b11)
  - state_t (S_IDLE, S_ACCUM)
  - function red_op(mode_t, a, b) for the bitwise combine
- One sub-module, reduce_lanes (combinational, parameters PORT_NUM and WIDTH, input mode, output WIDTH-bit word), instantiated once.
- The top holds the FSM, accumulator, beat counter and output register.

## Test plan
Defaults: PORT_NUM=8, WIDTH=7, CNT_W=8. Each result is checked on out_valid.
- **One-beat AND:** all lanes 7'h7F, mode 00, last=1 → out_data=7'h7F, out_flag=1, out_beats=1, out_err=0. Repeat with lane 3 set to 7'h7E → out_data=7'h7E, out_flag=0.
- **Three-beat OR:** beat data all lanes 0 except lane0 = 7'h01, then lane5 = 7'h10, then lane7 = 7'h40 (last on beat 3), mode 01 → out_data=7'h51, out_flag=1, out_beats=3. in_mode changed to 00 on beats 2-3 must have no effect.
- **Two-beat XOR:** beat 1 lanes = 7'h01..7'h08, beat 2 all lanes 7'h55 (even lane count, so 7'h00) → out_data=7'h08, out_flag=1.
- **Backpressure:**
  - out_ready=0, two consecutive one-beat frames: the second frame's last beat sees in_ready=0 and is held.
  - First result stays stable.
  - Raise out_ready: the second result appears the next cycle with no loss or duplication.
- **Reserved mode and saturation:**
  - Mode 11 one-beat frame → AND result and out_err=1.
  - CNT_W=2 build, 5-beat frame → out_beats=3, out_err=1.
- **Reset mid-frame:** reset after 2 of 4 beats, then a fresh one-beat OR of 7'h00 → out_data=7'h00 and out_beats=1, with no residue from the aborted frame.
